// File: rtl/range_ctrl_pkg.sv
// Shared types and constants for the range unit front-end controller.
package range_ctrl_pkg;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 1_000_000;

    // Bit positions of the pushbuttons within key_n.
    localparam int KEY_NEXT = 0;
    localparam int KEY_PREV = 1;
    localparam int KEY_HOME = 2;
    localparam int KEY_RUN  = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GO,
        ST_BUSY,
        ST_SHOW
    } state_t;

endpackage

// File: rtl/range_ctrl_key_debounce.sv
// One pushbutton: 2-flop synchronizer, level debouncer and a single-cycle
// pulse on each accepted released-to-pressed transition.
module key_debounce
    import range_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_n,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_reg;
    logic             sync2_reg;
    logic             stable_reg;
    logic             press_reg;
    logic [CNT_W-1:0] cnt_reg;

    // cnt_reg counts consecutive samples that disagree with the stable level;
    // any agreeing sample restarts the count.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_reg  <= 1'b1;
            sync2_reg  <= 1'b1;
            stable_reg <= 1'b1;
            cnt_reg    <= '0;
            press_reg  <= 1'b0;
        end else begin
            sync1_reg <= key_n;
            sync2_reg <= sync1_reg;
            press_reg <= 1'b0;
            if (sync2_reg == stable_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_LAST) begin
                stable_reg <= sync2_reg;
                cnt_reg    <= '0;
                press_reg  <= ~sync2_reg;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign press = press_reg;

endmodule

// File: rtl/range_ctrl.sv
// Pushbutton front-end for the Collatz range unit: launches runs and lets the
// user browse the result RAM, showing the value and its iteration count.
module range_ctrl
    import range_ctrl_pkg::*;
#(
    parameter int RAM_WORDS       = 256,
    parameter int RAM_ADDR_BITS   = 8,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [3:0]               key_n,
    input  logic [9:0]               sw,
    input  logic                     done,
    output logic                     go,
    output logic [31:0]              start,
    output logic [RAM_ADDR_BITS-1:0] rd_addr,
    input  logic [15:0]              rd_data,
    output logic [11:0]              disp_n,
    output logic [11:0]              disp_count,
    output logic                     count_valid,
    output logic                     busy
);

    localparam logic [RAM_ADDR_BITS-1:0] LAST_ADDR = RAM_ADDR_BITS'(RAM_WORDS - 1);

    logic [3:0] press;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_key
            key_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_key (
                .clk    (clk),
                .reset_n(reset_n),
                .key_n  (key_n[gi]),
                .press  (press[gi])
            );
        end
    endgenerate

    state_t                   state_reg;
    logic                     go_reg;
    logic                     busy_reg;
    logic [31:0]              start_reg;
    logic [RAM_ADDR_BITS-1:0] offset_reg;
    logic [RAM_ADDR_BITS-1:0] offset_next;
    logic                     primed_reg;
    logic                     count_valid_reg;
    logic [11:0]              disp_count_reg;
    logic [3:0]               rd_data_unused;

    assign rd_data_unused = rd_data[15:12];

    // Browsing result; home wins, opposing next/previous cancel out.
    always_comb begin
        offset_next = offset_reg;
        if (press[KEY_HOME]) begin
            offset_next = '0;
        end else if (press[KEY_NEXT] && !press[KEY_PREV]) begin
            offset_next = (offset_reg == LAST_ADDR) ? '0 : offset_reg + 1'b1;
        end else if (press[KEY_PREV] && !press[KEY_NEXT]) begin
            offset_next = (offset_reg == '0) ? LAST_ADDR : offset_reg - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg       <= ST_IDLE;
            go_reg          <= 1'b0;
            busy_reg        <= 1'b0;
            start_reg       <= '0;
            offset_reg      <= '0;
            primed_reg      <= 1'b0;
            count_valid_reg <= 1'b0;
            disp_count_reg  <= '0;
        end else begin
            go_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (press[KEY_RUN]) begin
                        start_reg <= {22'b0, sw};
                        go_reg    <= 1'b1;
                        state_reg <= ST_GO;
                    end
                end
                ST_GO: begin
                    busy_reg  <= 1'b1;
                    state_reg <= ST_BUSY;
                end
                ST_BUSY: begin
                    if (done) begin
                        busy_reg   <= 1'b0;
                        offset_reg <= '0;
                        state_reg  <= ST_SHOW;
                    end
                end
                ST_SHOW: begin
                    if (press[KEY_RUN]) begin
                        start_reg  <= {22'b0, sw};
                        offset_reg <= '0;
                        go_reg     <= 1'b1;
                        state_reg  <= ST_GO;
                    end else begin
                        offset_reg <= offset_next;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase

            // The RAM answers one cycle after rd_addr settles, so a count is
            // trusted only once the address has held for two edges.
            if (state_reg != ST_SHOW || press[KEY_RUN] || offset_next != offset_reg) begin
                primed_reg      <= 1'b0;
                count_valid_reg <= 1'b0;
            end else if (!primed_reg) begin
                primed_reg <= 1'b1;
            end else begin
                count_valid_reg <= 1'b1;
                disp_count_reg  <= rd_data[11:0];
            end
        end
    end

    assign go          = go_reg;
    assign busy        = busy_reg;
    assign start       = start_reg;
    assign rd_addr     = offset_reg;
    assign disp_n      = start_reg[11:0] + 12'(offset_reg);
    assign disp_count  = disp_count_reg;
    assign count_valid = count_valid_reg;

endmodule
